// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED pulse scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int DEF_ON_CYCLES  = 100_000_000;
  localparam int DEF_OFF_CYCLES = 50_000_000;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; LED_SCHED_CH0_PRIO_EN gives channel 0 strict priority.
module rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_id
);

  logic [N_CH-1:0]  rr_req;
  logic [PTR_W-1:0] idx;

  always_comb begin
    rr_req    = req;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
`ifdef LED_SCHED_CH0_PRIO_EN
    if (req[0]) begin
      gnt_valid = 1'b1;
      gnt_id    = '0;
    end
    // channel 0 never takes part in the rotation
    rr_req[0] = 1'b0;
`endif
    for (int k = 0; k < N_CH; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N_CH);
      if (!gnt_valid && rr_req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/led_pulse_scheduler.sv
// Replays queued per-channel pulses on one LED, round-robin, ON_CYCLES high then OFF_CYCLES low.
// Optional LED_SCHED_CH0_PRIO_EN: channel 0 strict priority, excluded from rr_ptr updates.
//   state | meaning
//   IDLE  | no replay, arbitrate pending counters
//   ON    | led high, timer counts ON_CYCLES
//   OFF   | led low gap, timer counts OFF_CYCLES
module led_pulse_scheduler
  import led_sched_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         pulse_in,
  output logic                    led,
  output logic                    busy,
  output logic [$clog2(N_CH)-1:0] grant_id,
  output logic                    pending_any,
  output logic [N_CH-1:0]         overflow
);

  localparam int ID_W    = $clog2(N_CH);
  localparam int TIMER_W = $clog2(max(ON_CYCLES, OFF_CYCLES) + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    next_ptr;
  logic [N_CH-1:0]    req;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               grant_now;

  rr_arbiter #(.N_CH(N_CH), .PTR_W(ID_W)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign grant_now   = (state == IDLE) && gnt_valid;
  assign pending_any = |req;
  assign next_ptr    = (gnt_id == ID_W'(N_CH - 1)) ? '0 : gnt_id + 1'b1;

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             dec;

    assign dec         = grant_now && (gnt_id == ID_W'(g));
    assign req[g]      = (count != '0);
    assign overflow[g] = ovf;

    always_ff @(posedge clk) begin
      if (rst) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (pulse_in[g] && !dec) begin
        if (count == CNT_MAX) ovf <= 1'b1;
        else                  count <= count + 1'b1;
      end else if (dec && !pulse_in[g]) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_valid) begin
          state    <= ON;
          led      <= 1'b1;
          busy     <= 1'b1;
          grant_id <= gnt_id;
          timer    <= ON_LOAD;
`ifdef LED_SCHED_CH0_PRIO_EN
          if (gnt_id != '0) rr_ptr <= next_ptr;
`else
          rr_ptr   <= next_ptr;
`endif
        end
        ON: if (timer == '0) begin
          state <= OFF;
          led   <= 1'b0;
          timer <= OFF_LOAD;
        end else begin
          timer <= timer - 1'b1;
        end
        OFF: if (timer == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          timer <= timer - 1'b1;
        end
        default: begin
          state <= IDLE;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/led_pulse_scheduler.md
Name: led_pulse_scheduler

Overview:
- Shares the single LED output among N_CH captured-pulse requesters.
- Each requester is a single-cycle pulse that is already synchronized and edge-detected; `posedge_detector` instances sit upstream.
- Each channel queues pending pulses in its own saturating counter.
- A round-robin scheduler replays one pulse at a time on the LED: high for ON_CYCLES, then low for OFF_CYCLES. The block sits between the per-input `posedge_detector` instances and the LED pin flop.

Parameters:
- N_CH, 4, number of requester channels (2..8)
- CNT_W, 8, width of each channel's pending counter
- ON_CYCLES, 100_000_000, LED-high duration in clk cycles (>=1)
- OFF_CYCLES, 50_000_000, mandatory LED-low gap after each replay (>=1)

Ports:
- clk  in  1  system clock (100 MHz from `clk_wiz_0`)
- rst  in  1  synchronous active-high reset
- pulse_in  in  N_CH  one-cycle request pulses, bit i = channel i
- led  out  1  registered LED drive
- busy  out  1  high while in ON or OFF
- grant_id  out  $clog2(N_CH)  channel currently being replayed; holds last value when idle
- pending_any  out  1  OR of all nonzero pending counters
- overflow  out  N_CH  sticky per channel; set when a pulse arrives at a saturated counter

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: all pending counters 0, state IDLE, led 0, busy 0, grant_id 0, overflow 0, rr_ptr 0, timer 0.
- Reset mid-operation: abort the replay immediately. led is 0 the cycle after rst is sampled, and queued pulses are discarded.
- Pending counter i, per cycle:
  - +1 if pulse_in[i] is high.
  - -1 if the channel is granted this cycle.
  - Simultaneous pulse and grant on the same channel: net 0.
  - Saturates at 2^CNT_W-1. A pulse at saturation with no grant sets overflow[i], and the count stays put.
- FSM states: IDLE, ON, OFF (enum from package).
- IDLE:
  - If any counter is nonzero, the arbiter picks the first nonzero channel starting at rr_ptr and wrapping modulo N_CH.
  - On that grant: decrement its counter, load grant_id, set rr_ptr = grant+1 (mod N_CH), timer = ON_CYCLES-1, go to ON.
  - A pulse arriving in IDLE is visible in its counter the next cycle. It is granted the cycle after that, and led rises on the following edge. Latency from pulse_in high to led high is 2 cycles.
- ON:
  - led = 1 for exactly ON_CYCLES cycles.
  - When timer = 0: timer = OFF_CYCLES-1, go to OFF.
  - Otherwise: timer -1.
- OFF:
  - led = 0 for exactly OFF_CYCLES cycles.
  - When timer = 0: go to IDLE.
  - Back-to-back: if a request is pending at that point, arbitration occurs on the IDLE cycle, so there is a 1-cycle IDLE between replays.
- led and busy are registered; led = (state==ON), busy = (state!=IDLE), both aligned to state.
- timer width: $clog2(max(ON_CYCLES,OFF_CYCLES)+1). The timer must not wrap.
- Pulses arriving during ON/OFF are queued and never lost, except at saturation.
- Wrap-around: rr_ptr at N_CH-1 advances to 0.

Optional Feature:
- LED_SCHED_CH0_PRIO_EN
- Defined: channel 0 has strict priority. In IDLE, a nonzero counter 0 is granted regardless of rr_ptr, and rr_ptr is not updated by channel-0 grants. The remaining channels stay round-robin among themselves.
- Undefined: pure round-robin across all channels, as above.

Decomposition:
- Package `led_sched_pkg`: state enum type (IDLE/ON/OFF), the default ON/OFF cycle constants, and a `max` helper for the timer width.
- One sub-module, `rr_arbiter`: inputs req vector and rr_ptr; outputs gnt_valid and gnt_id. It is combinational, with the priority option handled inside it under the same macro.

Test Plan (N_CH=4, CNT_W=2, ON_CYCLES=4, OFF_CYCLES=2):
- Single pulse on ch2 at cycle 10 -> led high cycles 12..15, low from 16, busy 12..17, grant_id=2, back to IDLE at 18.
- Pulses on ch0, ch1, ch3 in the same cycle, rr_ptr=0 -> replay order 0, 1, 3. Each replay is 4 high, 2 low, 1 IDLE; led rising edges are 7 cycles apart.
- 5 pulses on ch1 while busy with ch0 -> counter saturates at 3, overflow[1]=1 and sticky. Exactly 3 further ch1 replays follow, after which pending_any=0.
- Pulse on ch2 in the same cycle ch2 is granted (counter was 1) -> counter stays 1, and a second replay follows.
- rst asserted mid-ON with ch3 pending=2 -> led=0 next cycle, all counters 0, no further replays after reset release.
- With LED_SCHED_CH0_PRIO_EN, ch0 pulse arriving during the ch1 replay while ch2 is also pending -> ch0 is granted before ch2. Without the macro, ch2 is granted first.
